hub75_scan_driver: RTL and testbench
====================================

Name: hub75_scan_driver

Overview:
- Downstream consumer of the dual-buffered framebuffer.
- Generates framebuffer read requests: read enable, buffer select, half-panel address and bit-plane index.
- Takes the 6-bit {R0,G0,B0,R1,G1,B1} read data and drives a HUB75 chain (shift clock, latch, output enable, row address) using binary-code modulation (BCM).
- Owns the front/back buffer swap handshake with the frame writer.

Parameters:
- N_ROWS_MAX, 64, total panel rows; the scan covers N_ROWS_MAX/2 row pairs.
- N_COLS_MAX, 256, columns in the chain (panels × columns per panel).
- BITDEPTH_MAX, 8, maximum bits per colour.
- CTRL_WIDTH, 32, width of control inputs.
- BASE_ON_CYCLES, 16, number of OE-active cycles for bit plane 0.
- DEADTIME_CYCLES, 4, blanking cycles; used only with HUB75_DEADTIME_EN.
- Derived (do not change):
  - ROW_W = $clog2(N_ROWS_MAX/2)
  - COL_W = $clog2(N_COLS_MAX)
  - FB_ADDR_W = ROW_W + COL_W

Ports:
- clk  in  1  single clock; same clock as framebuffer r_clk.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_en  in  1  scan enable.
- ctrl_bitdepth  in  CTRL_WIDTH  active bits per colour, 1..BITDEPTH_MAX.
- swap_req  in  1  level; writer has finished the back buffer.
- swap_ack  out  1  one-cycle pulse when the buffers swap.
- fb_en  out  1  framebuffer read enable.
- fb_buffer  out  1  buffer being displayed.
- fb_addr  out  FB_ADDR_W  {row, col}.
- fb_bit  out  $clog2(BITDEPTH_MAX)  current bit plane.
- fb_rgb  in  6  framebuffer read data; valid exactly 1 cycle after fb_en.
- hub75_rgb  out  6  {R0,G0,B0,R1,G1,B1}.
- hub75_clk  out  1  panel shift clock.
- hub75_lat  out  1  panel latch.
- hub75_oe_n  out  1  panel output enable, active low.
- hub75_addr  out  ROW_W  panel row-pair address.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset values: hub75_oe_n=1; hub75_clk, hub75_lat, hub75_rgb, hub75_addr, fb_en, fb_addr, fb_bit, fb_buffer, swap_ack, frame_start all 0; FSM in IDLE.
- All outputs are registered.
- IDLE:
  - Leaves IDLE when ctrl_en=1.
  - On leaving: latch bitdepth, pulse frame_start, set row=0, bit=0, go to SHIFT.
- Bitdepth latch:
  - The value is captured only at frame start.
  - A value of 0 or a value above BITDEPTH_MAX latches as BITDEPTH_MAX.
- SHIFT (hub75_oe_n=1 throughout):
  - Issue one read per column, col 0..N_COLS_MAX-1.
  - Every 2 cycles: fb_en=1 with fb_addr={row,col}.
  - Load fb_rgb into hub75_rgb on the following cycle, with hub75_clk low.
  - Raise hub75_clk high for exactly 1 cycle after that.
  - Result: hub75_rgb changes only while hub75_clk=0, with ≥1 cycle of setup before each rising edge.
  - Exactly N_COLS_MAX hub75_clk pulses per plane.
  - fb_en=0 outside SHIFT.
  - fb_bit is constant during the plane.
- LATCH:
  - 1 cycle: hub75_lat=1, hub75_addr<=row, hub75_oe_n=1.
  - hub75_clk=0.
  - Go to DISPLAY.
- DISPLAY:
  - hub75_oe_n=0 for exactly BASE_ON_CYCLES << bit cycles.
  - Counter width is sufficient for BASE_ON_CYCLES << (BITDEPTH_MAX-1).
- After DISPLAY:
  - If bit < bitdepth-1: bit+1, same row, go to SHIFT.
  - Otherwise: bit=0, row+1, go to SHIFT.
  - Row wraps from N_ROWS_MAX/2-1 to 0; the wrap ends the frame.
- End of frame:
  - If swap_req=1: toggle fb_buffer and pulse swap_ack for 1 cycle in the same cycle.
  - Then, if ctrl_en=1: go to SHIFT with a new frame_start pulse and a re-latched bitdepth.
  - Otherwise go to IDLE with hub75_oe_n=1.
- ctrl_en deassertion mid-frame takes effect only at the frame boundary.
- swap_req is ignored mid-frame. It remains asserted until the writer sees swap_ack. The block never swaps twice per request only if the writer drops swap_req after swap_ack.
- Asynchronous reset mid-operation: all outputs return immediately to their reset values (display blanked); fb_buffer returns to 0.

Optional Feature:
- HUB75_DEADTIME_EN defined:
  - A DEAD state is inserted between SHIFT and LATCH.
  - hub75_oe_n=1 for DEADTIME_CYCLES cycles.
  - Additionally, DEADTIME_CYCLES blank cycles follow DISPLAY whenever the row changes, to suppress ghosting.
- Undefined: SHIFT goes directly to LATCH, and no extra blank cycles are added.

Test Plan:
- Bench config: N_ROWS_MAX=4, N_COLS_MAX=4, BITDEPTH_MAX=4, BASE_ON_CYCLES=2, ctrl_bitdepth=3; fb model returns fb_rgb={row,col}-derived pattern 1 cycle after fb_en.
- Reset release, ctrl_en=1 -> frame_start pulses once; first SHIFT issues fb_addr 0,1,2,3 with fb_bit=0; exactly 4 hub75_clk pulses; hub75_rgb matches model data at each rising edge.
- Full row -> oe_n low runs of 2, 4, 8 cycles for bits 0, 1, 2; one hub75_lat pulse precedes each run; hub75_addr=0; then row 1 begins.
- Frame wrap with swap_req=1 held from mid-frame -> after row 1 bit 2 DISPLAY: swap_ack 1 cycle, fb_buffer 0→1, next frame's reads carry fb_buffer=1; swap_req=0 at next frame end -> no toggle.
- ctrl_bitdepth=0 and =9 -> latched as 4 (planes 0..3, last run 16 cycles); change ctrl_bitdepth mid-frame to 1 -> no effect until next frame_start.
- ctrl_en dropped mid-row -> frame completes, then IDLE with oe_n=1, fb_en=0; rst_n asserted mid-SHIFT -> all outputs at reset values in the same cycle, fb_buffer=0.
- With HUB75_DEADTIME_EN, DEADTIME_CYCLES=4 -> 4 oe_n=1 cycles between the last hub75_clk and hub75_lat, plus 4 blank cycles after each row's last DISPLAY.

Source files
------------

// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: reads bit planes from the dual-buffered framebuffer,
// shifts them into the panel chain and shows each plane for a binary-weighted
// time (BCM). It also owns the front/back buffer swap handshake.
// Optional build macro: HUB75_DEADTIME_EN adds blanking before each latch
// and after the last plane of every row.
module hub75_scan_driver #(
    parameter int unsigned N_ROWS_MAX      = 64,
    parameter int unsigned N_COLS_MAX      = 256,
    parameter int unsigned BITDEPTH_MAX    = 8,
    parameter int unsigned CTRL_WIDTH      = 32,
    parameter int unsigned BASE_ON_CYCLES  = 16,
    parameter int unsigned DEADTIME_CYCLES = 4,
    localparam int unsigned ROW_W     = $clog2(N_ROWS_MAX / 2),
    localparam int unsigned COL_W     = $clog2(N_COLS_MAX),
    localparam int unsigned FB_ADDR_W = ROW_W + COL_W,
    localparam int unsigned BIT_W     = $clog2(BITDEPTH_MAX)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_en,
    input  logic [CTRL_WIDTH-1:0] ctrl_bitdepth,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  fb_en,
    output logic                  fb_buffer,
    output logic [FB_ADDR_W-1:0]  fb_addr,
    output logic [BIT_W-1:0]      fb_bit,
    input  logic [5:0]            fb_rgb,
    output logic [5:0]            hub75_rgb,
    output logic                  hub75_clk,
    output logic                  hub75_lat,
    output logic                  hub75_oe_n,
    output logic [ROW_W-1:0]      hub75_addr,
    output logic                  frame_start
);

    // Widths of the plane count and of the shared phase counter.
    localparam int unsigned BD_W       = $clog2(BITDEPTH_MAX + 1);
    localparam int unsigned SHIFT_LAST = 2 * N_COLS_MAX + 1;
    localparam int unsigned SHIFT_RDS  = 2 * N_COLS_MAX;
    localparam int unsigned DISP_MAX   = BASE_ON_CYCLES << (BITDEPTH_MAX - 1);
    localparam int unsigned DT_LAST    = (DEADTIME_CYCLES > 0) ? DEADTIME_CYCLES - 1 : 0;
    localparam int unsigned CNT_MAX_A  = (SHIFT_LAST > DISP_MAX) ? SHIFT_LAST : DISP_MAX;
    localparam int unsigned CNT_MAX    = (CNT_MAX_A > DEADTIME_CYCLES) ? CNT_MAX_A : DEADTIME_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned ROW_LAST   = N_ROWS_MAX / 2 - 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_DEAD    = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_DISPLAY = 3'd4;
    localparam logic [2:0] S_BLANK   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [BD_W-1:0]      bd_q, bd_d;
    logic                 rd_vld_q;

    logic [BIT_W-1:0]     bit_d;
    logic                 buf_d;
    logic                 row_done;
    logic                 start_frame;
    logic                 ack_d;
    logic                 fb_en_d;
    logic [FB_ADDR_W-1:0] fb_addr_d;
    logic [5:0]           rgb_d;
    logic                 clk_d;
    logic                 lat_d;
    logic                 oe_n_d;
    logic [ROW_W-1:0]     haddr_d;

    logic [BD_W-1:0]      bd_sat_c;
    logic                 disp_last_c;
    logic                 plane_last_c;

    // Out-of-range plane counts fall back to the full depth.
    always_comb begin
        bd_sat_c = BD_W'(ctrl_bitdepth);
        if (ctrl_bitdepth == '0 || ctrl_bitdepth > CTRL_WIDTH'(BITDEPTH_MAX)) begin
            bd_sat_c = BD_W'(BITDEPTH_MAX);
        end
    end

    // End of the binary-weighted on-time and last-plane-of-row detection.
    always_comb begin
        disp_last_c  = (cnt_q == CNT_W'((BASE_ON_CYCLES << fb_bit) - 32'd1));
        plane_last_c = ((BD_W'(fb_bit) + BD_W'(1)) >= bd_q);
    end

    // Next-state logic; outputs are then derived from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        row_d       = row_q;
        bit_d       = fb_bit;
        bd_d        = bd_q;
        buf_d       = fb_buffer;
        row_done    = 1'b0;
        start_frame = 1'b0;
        ack_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ctrl_en) begin
                    start_frame = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(SHIFT_LAST)) begin
                    cnt_d = '0;
`ifdef HUB75_DEADTIME_EN
                    state_d = S_DEAD;
`else
                    state_d = S_LATCH;
`endif
                end
            end
            S_DEAD: begin
                if (cnt_q == CNT_W'(DT_LAST)) begin
                    cnt_d   = '0;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                cnt_d   = '0;
                state_d = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (disp_last_c) begin
                    cnt_d = '0;
                    if (!plane_last_c) begin
                        bit_d   = fb_bit + BIT_W'(1);
                        state_d = S_SHIFT;
                    end else begin
                        bit_d = '0;
`ifdef HUB75_DEADTIME_EN
                        state_d = S_BLANK;
`else
                        row_done = 1'b1;
`endif
                    end
                end
            end
            S_BLANK: begin
                if (cnt_q == CNT_W'(DT_LAST)) begin
                    cnt_d    = '0;
                    row_done = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Row advance; the wrap is the frame boundary where swap and restart happen.
        if (row_done) begin
            if (row_q == ROW_W'(ROW_LAST)) begin
                row_d = '0;
                if (swap_req) begin
                    buf_d = ~fb_buffer;
                    ack_d = 1'b1;
                end
                if (ctrl_en) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end else begin
                row_d   = row_q + ROW_W'(1);
                state_d = S_SHIFT;
            end
        end

        if (start_frame) begin
            bd_d    = bd_sat_c;
            row_d   = '0;
            bit_d   = '0;
            cnt_d   = '0;
            state_d = S_SHIFT;
        end

        // Reads on even shift phases, shift clock on odd phases from 3 onward.
        fb_en_d   = (state_d == S_SHIFT) && !cnt_d[0] && (cnt_d < CNT_W'(SHIFT_RDS));
        clk_d     = (state_d == S_SHIFT) && cnt_d[0] && (cnt_d >= CNT_W'(3));
        fb_addr_d = fb_en_d ? {row_d, COL_W'(cnt_d >> 1)} : fb_addr;
        rgb_d     = rd_vld_q ? fb_rgb : hub75_rgb;
        lat_d     = (state_d == S_LATCH);
        haddr_d   = (state_d == S_LATCH) ? row_d : hub75_addr;
        oe_n_d    = (state_d != S_DISPLAY);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            bd_q        <= BD_W'(BITDEPTH_MAX);
            rd_vld_q    <= 1'b0;
            fb_bit      <= '0;
            fb_buffer   <= 1'b0;
            fb_en       <= 1'b0;
            fb_addr     <= '0;
            hub75_rgb   <= '0;
            hub75_clk   <= 1'b0;
            hub75_lat   <= 1'b0;
            hub75_oe_n  <= 1'b1;
            hub75_addr  <= '0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            bd_q        <= bd_d;
            rd_vld_q    <= fb_en;
            fb_bit      <= bit_d;
            fb_buffer   <= buf_d;
            fb_en       <= fb_en_d;
            fb_addr     <= fb_addr_d;
            hub75_rgb   <= rgb_d;
            hub75_clk   <= clk_d;
            hub75_lat   <= lat_d;
            hub75_oe_n  <= oe_n_d;
            hub75_addr  <= haddr_d;
            swap_ack    <= ack_d;
            frame_start <= start_frame;
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver on a 4-row, 4-column, 4-bit panel.
module tb_hub75_scan_driver;

    localparam int unsigned NR   = 4;
    localparam int unsigned NC   = 4;
    localparam int unsigned BDM  = 4;
    localparam int unsigned CW   = 32;
    localparam int unsigned BASE = 2;
    localparam int unsigned DTC  = 4;
`ifdef HUB75_DEADTIME_EN
    localparam int DT = 4;
`else
    localparam int DT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_en = 1'b0;
    logic [31:0] ctrl_bitdepth = 32'd3;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        fb_en;
    logic        fb_buffer;
    logic [2:0]  fb_addr;
    logic [1:0]  fb_bit;
    logic [5:0]  fb_rgb = 6'h00;
    logic [5:0]  hub75_rgb;
    logic        hub75_clk;
    logic        hub75_lat;
    logic        hub75_oe_n;
    logic [0:0]  hub75_addr;
    logic        frame_start;

    int n_vec = 0;
    int n_err = 0;
    int fs_seen = 0;
    int ack_seen = 0;

    hub75_scan_driver #(
        .N_ROWS_MAX      (NR),
        .N_COLS_MAX      (NC),
        .BITDEPTH_MAX    (BDM),
        .CTRL_WIDTH      (CW),
        .BASE_ON_CYCLES  (BASE),
        .DEADTIME_CYCLES (DTC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl_en       (ctrl_en),
        .ctrl_bitdepth (ctrl_bitdepth),
        .swap_req      (swap_req),
        .swap_ack      (swap_ack),
        .fb_en         (fb_en),
        .fb_buffer     (fb_buffer),
        .fb_addr       (fb_addr),
        .fb_bit        (fb_bit),
        .fb_rgb        (fb_rgb),
        .hub75_rgb     (hub75_rgb),
        .hub75_clk     (hub75_clk),
        .hub75_lat     (hub75_lat),
        .hub75_oe_n    (hub75_oe_n),
        .hub75_addr    (hub75_addr),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    // Pixel data derived from address, plane and buffer; never zero.
    function automatic logic [5:0] pat(input int addr, input int bitn, input int bufv);
        return 6'((addr * 7 + bitn * 11 + bufv * 29) % 63 + 1);
    endfunction

    // Framebuffer model: data valid one cycle after the read enable.
    always @(posedge clk) begin
        fb_rgb <= fb_en ? pat(int'(fb_addr), int'(fb_bit), int'(fb_buffer)) : 6'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; acts as the writer dropping swap_req on swap_ack.
    task automatic step();
        @(negedge clk);
        if (frame_start) fs_seen++;
        if (swap_ack) begin
            ack_seen++;
            swap_req = 1'b0;
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({hub75_oe_n, hub75_clk, hub75_lat, hub75_addr, hub75_rgb,
                    fb_en, fb_addr, fb_bit, fb_buffer, swap_ack, frame_start});
    endfunction

    // One bit plane: shift, (dead time), latch, display.
    task automatic run_plane(input int row, input int bitn, input int bufv,
                             input int exp_pre, input int exp_fs);
        int waited, reads, clks, idx, last_clk, run, bad_shape, oe_low;
        logic prev_clk;
        logic [5:0] prev_rgb;
        waited = 0;
        while (!fb_en && waited < 100) begin
            step();
            waited++;
        end
        if (!fb_en) begin
            check("rd_start", 32'(fb_en), 32'd1);
            return;
        end
        if (exp_pre >= 0) check("pre_gap", 32'(waited), 32'(exp_pre));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        reads = 0; clks = 0; idx = 0; last_clk = -100; run = 0;
        bad_shape = 0; oe_low = 0; prev_clk = 1'b0; prev_rgb = hub75_rgb;
        while (!hub75_lat && idx < 100) begin
            if (fb_en) begin
                check("rd_addr", 32'(fb_addr), 32'(row * int'(NC) + reads));
                check("rd_bit", 32'(fb_bit), 32'(bitn));
                check("rd_buf", 32'(fb_buffer), 32'(bufv));
                reads++;
            end
            if (hub75_clk && !prev_clk) begin
                check("rgb_at_edge", 32'(hub75_rgb), 32'(pat(row * int'(NC) + clks, bitn, bufv)));
                clks++;
                last_clk = idx;
            end
            if (hub75_clk && (prev_clk || hub75_rgb != prev_rgb)) bad_shape++;
            if (!hub75_oe_n) oe_low++;
            prev_clk = hub75_clk;
            prev_rgb = hub75_rgb;
            step();
            idx++;
        end
        check("lat_seen", 32'(hub75_lat), 32'd1);
        check("n_reads", 32'(reads), 32'(NC));
        check("n_clk", 32'(clks), 32'(NC));
        check("dead_gap", 32'(idx - last_clk - 1), 32'(DT));
        check("clk_shape", 32'(bad_shape), 32'd0);
        check("oe_in_shift", 32'(oe_low), 32'd0);
        check("hub_addr", 32'(hub75_addr), 32'(row));
        check("lat_oe_clk", 32'({hub75_oe_n, hub75_clk}), 32'd2);
        step();
        while (!hub75_oe_n && run < 200) begin
            step();
            run++;
        end
        check("oe_run", 32'(run), 32'(BASE << bitn));
    endtask

    // Whole frame of two row pairs; act is applied between the rows.
    task automatic run_frame(input int nbits, input int bufv, input bit from_idle,
                             input int act, input int exp_fs, input int exp_ack);
        int pre;
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < nbits; b++) begin
                if (r == 0 && b == 0) pre = from_idle ? -1 : DT;
                else pre = (b == 0) ? DT : 0;
                run_plane(r, b, bufv, pre, (r == 0 && b == 0) ? 1 : 0);
                if (r == 0 && b == 0) begin
                    check("fs_total", 32'(fs_seen), 32'(exp_fs));
                    check("ack_total", 32'(ack_seen), 32'(exp_ack));
                end
            end
            if (r == 0) begin
                case (act)
                    1: begin swap_req = 1'b1; ctrl_bitdepth = 32'd0; end
                    2: ctrl_bitdepth = 32'd9;
                    3: ctrl_bitdepth = 32'd1;
                    4: ctrl_en = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en_cnt, oe_cnt, waited;
        repeat (3) step();
        check("reset_outputs", out_vec(), 32'h0004_0000);
        rst_n = 1'b1;
        repeat (5) step();
        check("idle_outputs", out_vec(), 32'h0004_0000);
        check("idle_no_fs", 32'(fs_seen), 32'd0);

        ctrl_en = 1'b1;
        run_frame(3, 0, 1'b1, 1, 1, 0);
        run_frame(4, 1, 1'b0, 2, 2, 1);
        run_frame(4, 1, 1'b0, 3, 3, 1);
        run_frame(1, 1, 1'b0, 4, 4, 1);

        en_cnt = 0; oe_cnt = 0;
        repeat (20) begin
            step();
            if (fb_en) en_cnt++;
            if (!hub75_oe_n) oe_cnt++;
        end
        check("idle_fb_en", 32'(en_cnt), 32'd0);
        check("idle_oe_low", 32'(oe_cnt), 32'd0);
        check("idle_fs_total", 32'(fs_seen), 32'd4);
        check("idle_ack_total", 32'(ack_seen), 32'd1);
        check("idle_buf", 32'(fb_buffer), 32'd1);

        ctrl_bitdepth = 32'd3;
        ctrl_en = 1'b1;
        waited = 0;
        while (!fb_en && waited < 20) begin
            step();
            waited++;
        end
        check("restart_rd", 32'(fb_en), 32'd1);
        repeat (3) step();
        check("buf_before_rst", 32'(fb_buffer), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", out_vec(), 32'h0004_0000);
        check("async_reset_buf", 32'(fb_buffer), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
